// File: rtl/pulse_pkg.sv
// Shared types and timing defaults for the pulse emit/capture path.
// Holds declarations only: no logic, no latency, no flow control.
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } pulse_state_t;

    localparam int CLK_HZ         = 100_000_000;
    localparam int ONE_SEC_CYCLES = CLK_HZ;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pending_counter.sv
// Saturating up/down counter of queued requests. The count updates one cycle after inc/dec.
// Back-pressure: an inc at full with no dec is dropped and reported on o_ovf_set.
module pending_counter
    import pulse_pkg::*;
#(
    parameter  int MAX_COUNT = 15,
    localparam int CW        = $clog2(MAX_COUNT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty,
    output logic          o_ovf_set
);

    localparam logic [CW-1:0] FULL_VAL = CW'(MAX_COUNT);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] r_count;
    logic          w_inc_ok;
    logic          w_dec_ok;

    assign o_full  = (r_count == FULL_VAL);
    assign o_empty = (r_count == '0);

    // A same-cycle dec frees the slot, so an inc at full is still accepted then.
    assign w_dec_ok  = i_dec && !o_empty;
    assign w_inc_ok  = i_inc && (!o_full || w_dec_ok);
    assign o_ovf_set = i_inc && !w_inc_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_inc_ok && !w_dec_ok) begin
            r_count <= r_count + ONE;
        end else if (w_dec_ok && !w_inc_ok) begin
            r_count <= r_count - ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pulse_emitter.sv
// Queues trigger strobes and emits one fixed-width pulse per trigger with a guaranteed low gap.
// Latency: pending after 1 edge, pulse_out after 2. Full queue drops triggers and sets sticky overflow.
module pulse_emitter
    import pulse_pkg::*;
#(
    parameter  int PULSE_CYCLES = ONE_SEC_CYCLES,
    parameter  int GAP_CYCLES   = ONE_SEC_CYCLES,
    parameter  int MAX_PENDING  = 15,
    localparam int PW           = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          trigger,
    input  logic          enable,
    input  logic          clear_ovf,
    output logic          pulse_out,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          overflow
);

    localparam int            CW         = $clog2(max_int(PULSE_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    pulse_state_t  r_state;
    pulse_state_t  w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_pulse;
    logic          w_pulse_nxt;
    logic          r_busy;
    logic          w_busy_nxt;
    logic          r_ovf;
    logic          w_deq;
    logic          w_full;
    logic          w_empty;
    logic          w_ovf_set;

    pending_counter #(
        .MAX_COUNT (MAX_PENDING)
    ) u_pending (
        .clk       (clk),
        .reset     (reset),
        .i_inc     (trigger),
        .i_dec     (w_deq),
        .o_count   (pending),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_ovf_set (w_ovf_set)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pulse_nxt = r_pulse;
        w_busy_nxt  = r_busy;
        w_deq       = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && !w_empty) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = '0;
                    w_pulse_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_deq       = 1'b1;
                end
            end
            HIGH: begin
                if (r_cnt == PULSE_LAST) begin
                    w_state_nxt = GAP;
                    w_cnt_nxt   = '0;
                    w_pulse_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            GAP: begin
                // Leaving through IDLE adds one more low cycle before the next rise.
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
                w_pulse_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pulse <= w_pulse_nxt;
            r_busy  <= w_busy_nxt;
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (clear_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!reset) w_ovf_set |-> w_full);
    assert property (@(posedge clk) disable iff (!reset) r_pulse |-> r_busy);

    assign pulse_out = r_pulse;
    assign busy      = r_busy;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_pulse_emitter.sv
// Bench for pulse_emitter: directed scenarios plus random traffic against a timing-arithmetic model.
// Per-cycle expectations and pulse start times are queued by the model and consumed by a monitor.
module tb_pulse_emitter;

    localparam int P  = 4;
    localparam int G  = 3;
    localparam int M  = 3;
    localparam int PW = 2;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          trigger   = 1'b0;
    logic          enable    = 1'b0;
    logic          clear_ovf = 1'b0;
    logic          pulse_out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    pulse_emitter #(
        .PULSE_CYCLES (P),
        .GAP_CYCLES   (G),
        .MAX_PENDING  (M)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .trigger   (trigger),
        .enable    (enable),
        .clear_ovf (clear_ovf),
        .pulse_out (pulse_out),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          p;
        logic          b;
        logic [PW-1:0] pend;
        logic          o;
    } st_t;

    st_t exp_q[$];
    int  start_q[$];
    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc      = 0;
    int  n_rise   = 0;

    // Model state: queue depth, sticky flag, and the time of the last pulse start.
    int  m_pend    = 0;
    bit  m_ovf     = 1'b0;
    bit  m_started = 1'b0;
    int  m_last    = 0;
    int  m_next_ok = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge reset) begin
        m_pend    = 0;
        m_ovf     = 1'b0;
        m_started = 1'b0;
        m_next_ok = 0;
        start_q.delete();
    end

    always @(posedge clk) begin
        bit  start;
        bit  drop;
        st_t e;
        cyc++;
        if (!reset) begin
            m_pend    = 0;
            m_ovf     = 1'b0;
            m_started = 1'b0;
            m_next_ok = 0;
            exp_q.push_back('0);
        end else begin
            start = enable && (m_pend > 0) && (cyc >= m_next_ok);
            drop  = trigger && !start && (m_pend == M);
            if (!drop) m_pend = m_pend + int'(trigger) - int'(start);
            if (drop) m_ovf = 1'b1;
            else if (clear_ovf) m_ovf = 1'b0;
            if (start) begin
                m_started = 1'b1;
                m_last    = cyc;
                m_next_ok = cyc + P + G + 1;
                start_q.push_back(cyc);
            end
            e.p    = m_started && (cyc < m_last + P);
            e.b    = m_started && (cyc < m_last + P + G);
            e.pend = PW'(m_pend);
            e.o    = m_ovf;
            exp_q.push_back(e);
        end
    end

    logic prev_p = 1'b0;

    always begin
        st_t e;
        st_t got;
        @(posedge clk);
        #3;
        got.p    = pulse_out;
        got.b    = busy;
        got.pend = pending;
        got.o    = overflow;
        if (exp_q.size() == 0) begin
            chk("expect_queue_nonempty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
                n_errors++;
                $display("FAIL status cycle %0d: got pulse=%b busy=%b pending=%0d ovf=%b, expected pulse=%b busy=%b pending=%0d ovf=%b",
                         cyc, got.p, got.b, got.pend, got.o, e.p, e.b, e.pend, e.o);
            end
        end
        if (pulse_out === 1'b1 && prev_p !== 1'b1) begin
            n_rise++;
            if (start_q.size() == 0) chk("pulse_unexpected", 32'd1, 32'd0);
            else chk("pulse_start_cycle", cyc, start_q.pop_front());
        end
        prev_p = pulse_out;
    end

    task automatic step(input logic t, input logic en, input logic c);
        @(negedge clk);
        trigger   = t;
        enable    = en;
        clear_ovf = c;
    endtask

    task automatic idle(input int n, input logic en);
        repeat (n) step(1'b0, en, 1'b0);
    endtask

    initial begin
        int r0;
        int r1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_pulse_out", pulse_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_pending", pending, 0);
        chk("reset_overflow", overflow, 0);
        @(negedge clk);
        reset = 1'b1;
        idle(8, 1'b1);

        // Single trigger
        r0 = n_rise;
        step(1'b1, 1'b1, 1'b0);
        idle(20, 1'b1);
        chk("t1_pulse_count", n_rise - r0, 1);

        // Three back-to-back triggers
        r0 = n_rise;
        repeat (3) step(1'b1, 1'b1, 1'b0);
        idle(30, 1'b1);
        chk("t2_pulse_count", n_rise - r0, 3);
        chk("t2_no_overflow", overflow, 0);

        // Five triggers: one dropped at full
        r0 = n_rise;
        repeat (5) step(1'b1, 1'b1, 1'b0);
        idle(40, 1'b1);
        chk("t3_pulse_count", n_rise - r0, 4);
        chk("t3_overflow_sticky", overflow, 1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        chk("t3_overflow_cleared", overflow, 0);

        // Disabled queueing, then release
        r0 = n_rise;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        idle(8, 1'b0);
        chk("t4_pending_held", pending, 2);
        chk("t4_no_pulse_disabled", pulse_out, 0);
        idle(25, 1'b1);
        chk("t4_pulse_count", n_rise - r0, 2);

        // Asynchronous reset mid-pulse
        repeat (3) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("t5_mid_pulse_high", pulse_out, 1);
        chk("t5_pending_before_reset", pending, 2);
        @(negedge clk);
        r1 = n_rise;
        reset = 1'b0;
        #1;
        chk("t5_async_pulse_out", pulse_out, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_pending", pending, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle(15, 1'b1);
        chk("t5_no_pulse_after_reset", n_rise - r1, 0);

        // Drop and clear in the same cycle: set wins
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("t6_set_wins", overflow, 1);
        chk("t6_pending_full", pending, 3);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("t6_clear_alone", overflow, 0);
        r0 = n_rise;
        idle(30, 1'b1);
        chk("t6_drain_count", n_rise - r0, 3);

        // Random traffic
        repeat (600) begin
            step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 5);
        end
        idle(60, 1'b1);
        chk("pulse_queue_drained", start_q.size(), 0);
        chk("pending_drained", pending, 0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
